// File: rtl/counter_monitor_pkg.sv
// Shared types and default sizes for the counter monitor and its snapshot path.
// Kept separate so the testbench and the readout logic can size themselves from the same constants.
package counter_monitor_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_WRAP_W = 16;
    localparam int DEF_ERR_W  = 8;

    typedef enum logic [1:0] {
        SYNC,
        TRACK,
        FAULT
    } mon_state_e;

endpackage

// File: rtl/counter_monitor_if.sv
// Snapshot valid/ready channel between the counter monitor (master) and the readout logic (slave).
interface counter_monitor_if #(
    parameter int WIDTH  = counter_monitor_pkg::DEF_WIDTH,
    parameter int WRAP_W = counter_monitor_pkg::DEF_WRAP_W
);

    logic                    snap_req_i;
    logic                    snap_valid_o;
    logic                    snap_ready_i;
    logic [WRAP_W+WIDTH-1:0] snap_data_o;

    modport master (
        input  snap_req_i,
        input  snap_ready_i,
        output snap_valid_o,
        output snap_data_o
    );

    modport slave (
        output snap_req_i,
        output snap_ready_i,
        input  snap_valid_o,
        input  snap_data_o
    );

endinterface

// File: rtl/counter_monitor_snapshot.sv
// One-entry valid/ready holding register. A capture is only taken when the slot is
// empty or being drained on the same edge; otherwise the request is dropped.
module counter_monitor_snapshot #(
    parameter int DATA_W = 24
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              capture_i,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic accept;

    assign accept = capture_i && (!valid_o || ready_i);

    // Held data only moves on an accepted capture, so it is stable while stalled.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (accept) begin
            valid_o <= 1'b1;
            data_o  <= data_i;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/counter_monitor.sv
// Checks that the upstream counter advances by exactly one per enabled sample, counts
// wraps and mismatches, and offers {wrap count, counter value} snapshots to readout.
module counter_monitor
    import counter_monitor_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WRAP_W = DEF_WRAP_W,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [WIDTH-1:0]  cnt_i,
    input  logic              en_i,
    output logic              wrap_o,
    output logic              err_o,
    input  logic              err_clr_i,
    output logic [ERR_W-1:0]  err_cnt_o,
    counter_monitor_if.master snap
);

    mon_state_e               state_q;
    logic [WIDTH-1:0]         prev_q;
    logic [WRAP_W-1:0]        wrap_cnt_q;
    logic [WIDTH-1:0]         expected;
    logic                     compare_en;
    logic                     in_step;
    logic                     new_err;
    logic                     wrap_hit;
    logic [WRAP_W-1:0]        wrap_cnt_next;
    logic                     snap_valid;
    logic [WRAP_W+WIDTH-1:0]  snap_data;

    // SYNC only learns the first value; only a TRACK->FAULT transition counts as a new error.
    always_comb begin
        expected      = prev_q + 1'b1;
        compare_en    = en_i && (state_q != SYNC);
        in_step       = (cnt_i == expected);
        new_err       = compare_en && (state_q == TRACK) && !in_step;
        wrap_hit      = compare_en && (prev_q == '1) && (cnt_i == '0);
        wrap_cnt_next = wrap_cnt_q + WRAP_W'(wrap_hit);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= SYNC;
            prev_q     <= '0;
            wrap_cnt_q <= '0;
            wrap_o     <= 1'b0;
            err_o      <= 1'b0;
            err_cnt_o  <= '0;
        end else begin
            wrap_o     <= wrap_hit;
            wrap_cnt_q <= wrap_cnt_next;

            // A fresh mismatch beats a simultaneous clear and restarts the count at one.
            if (new_err) begin
                err_o <= 1'b1;
                if (err_clr_i) begin
                    err_cnt_o <= ERR_W'(1);
                end else if (err_cnt_o != '1) begin
                    err_cnt_o <= err_cnt_o + 1'b1;
                end
            end else if (err_clr_i) begin
                err_o     <= 1'b0;
                err_cnt_o <= '0;
            end

            if (!en_i) begin
                state_q <= SYNC;
            end else begin
                prev_q <= cnt_i;
                case (state_q)
                    SYNC:    state_q <= TRACK;
                    TRACK:   if (!in_step) state_q <= FAULT;
                    FAULT:   if (in_step) state_q <= TRACK;
                    default: state_q <= SYNC;
                endcase
            end
        end
    end

    counter_monitor_snapshot #(
        .DATA_W (WRAP_W + WIDTH)
    ) u_snapshot (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .capture_i (snap.snap_req_i),
        .ready_i   (snap.snap_ready_i),
        .data_i    ({wrap_cnt_next, cnt_i}),
        .valid_o   (snap_valid),
        .data_o    (snap_data)
    );

    assign snap.snap_valid_o = snap_valid;
    assign snap.snap_data_o  = snap_data;

endmodule

// File: tb/tb_counter_monitor.sv
// Drives counter_monitor with directed sequences and randomized traffic, comparing every
// cycle against a behavioural model of the monitoring rules.
module tb_counter_monitor;

    localparam int WIDTH  = 8;
    localparam int WRAP_W = 16;
    localparam int ERR_W  = 8;
    localparam int MOD    = 1 << WIDTH;
    localparam int WMOD   = 1 << WRAP_W;
    localparam int ERRMAX = (1 << ERR_W) - 1;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [WIDTH-1:0] cnt_i;
    logic             en_i;
    logic             wrap_o;
    logic             err_o;
    logic             err_clr_i;
    logic [ERR_W-1:0] err_cnt_o;

    int num_compared   = 0;
    int num_mismatched = 0;

    // Behavioural model state
    bit m_have_prev;
    int m_prev;
    bit m_ok;
    bit m_err;
    int m_err_cnt;
    int m_wrap_cnt;
    bit m_wrap_pulse;
    bit m_valid;
    int m_data;

    counter_monitor_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) snap_if ();

    counter_monitor #(
        .WIDTH  (WIDTH),
        .WRAP_W (WRAP_W),
        .ERR_W  (ERR_W)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .cnt_i     (cnt_i),
        .en_i      (en_i),
        .wrap_o    (wrap_o),
        .err_o     (err_o),
        .err_clr_i (err_clr_i),
        .err_cnt_o (err_cnt_o),
        .snap      (snap_if.master)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_compared++;
        if (observed !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_have_prev  = 1'b0;
        m_prev       = 0;
        m_ok         = 1'b1;
        m_err        = 1'b0;
        m_err_cnt    = 0;
        m_wrap_cnt   = 0;
        m_wrap_pulse = 1'b0;
        m_valid      = 1'b0;
        m_data       = 0;
    endtask

    task automatic modelStep(input int cnt, input bit en, input bit clr, input bit req, input bit ready);
        bit wrapped;
        bit new_err;
        bit in_step;
        wrapped = 1'b0;
        new_err = 1'b0;
        if (en) begin
            if (m_have_prev) begin
                in_step = (cnt == (m_prev + 1) % MOD);
                wrapped = (m_prev == MOD - 1) && (cnt == 0);
                new_err = !in_step && m_ok;
                m_ok    = in_step;
            end else begin
                m_ok = 1'b1;
            end
            m_have_prev = 1'b1;
            m_prev      = cnt;
        end else begin
            m_have_prev = 1'b0;
        end
        m_wrap_cnt   = (m_wrap_cnt + (wrapped ? 1 : 0)) % WMOD;
        m_wrap_pulse = wrapped;
        if (new_err) begin
            m_err     = 1'b1;
            m_err_cnt = clr ? 1 : ((m_err_cnt < ERRMAX) ? m_err_cnt + 1 : ERRMAX);
        end else if (clr) begin
            m_err     = 1'b0;
            m_err_cnt = 0;
        end
        if (req && (!m_valid || ready)) begin
            m_valid = 1'b1;
            m_data  = m_wrap_cnt * MOD + cnt;
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int cnt, input bit en, input bit clr, input bit req, input bit ready);
        cnt_i                = WIDTH'(cnt);
        en_i                 = en;
        err_clr_i            = clr;
        snap_if.snap_req_i   = req;
        snap_if.snap_ready_i = ready;
        @(posedge clk_i);
        #1;
        modelStep(cnt, en, clr, req, ready);
        checkOutput("wrap_o", 32'(wrap_o), 32'(m_wrap_pulse));
        checkOutput("err_o", 32'(err_o), 32'(m_err));
        checkOutput("err_cnt_o", 32'(err_cnt_o), m_err_cnt);
        checkOutput("snap_valid_o", 32'(snap_if.snap_valid_o), 32'(m_valid));
        checkOutput("snap_data_o", 32'(snap_if.snap_data_o), m_data);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_wrap"}, 32'(wrap_o), 0);
        checkOutput({tag, "_err"}, 32'(err_o), 0);
        checkOutput({tag, "_err_cnt"}, 32'(err_cnt_o), 0);
        checkOutput({tag, "_valid"}, 32'(snap_if.snap_valid_o), 0);
        checkOutput({tag, "_data"}, 32'(snap_if.snap_data_o), 0);
    endtask

    task automatic doReset();
        reset_i              = 1'b1;
        en_i                 = 1'b0;
        err_clr_i            = 1'b0;
        snap_if.snap_req_i   = 1'b0;
        snap_if.snap_ready_i = 1'b0;
        modelReset();
        #1;
        checkAllZero("reset");
        #19;
        reset_i = 1'b0;
    endtask

    initial begin
        int upc;
        int wraps_seen;
        int v;
        int drv;
        bit r_en;
        bit r_clr;
        bit r_req;
        bit r_rdy;
        int r;

        cnt_i = '0;
        doReset();

        // Free-running upstream counter for 300 cycles: exactly one wrap
        upc = 0;
        wraps_seen = 0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(upc, 1, 0, 0, 0);
            if (wrap_o) wraps_seen++;
            upc = (upc + 1) % MOD;
        end
        checkOutput("run_wraps_seen", wraps_seen, 1);
        checkOutput("run_err_o", 32'(err_o), 0);
        while (upc != 99) begin
            applyStimulus(upc, 1, 0, 0, 0);
            upc = (upc + 1) % MOD;
        end
        applyStimulus(99, 1, 0, 1, 0);
        applyStimulus(100, 1, 0, 1, 1);
        checkOutput("req_ready_valid", 32'(snap_if.snap_valid_o), 1);
        checkOutput("req_ready_data", 32'(snap_if.snap_data_o), 32'h0001_64);

        // Single skipped value, recovery, then a fresh mismatch from TRACK
        doReset();
        applyStimulus(10, 1, 0, 0, 0);
        applyStimulus(11, 1, 0, 0, 0);
        applyStimulus(13, 1, 0, 0, 0);
        checkOutput("skip_err_o", 32'(err_o), 1);
        checkOutput("skip_err_cnt", 32'(err_cnt_o), 1);
        applyStimulus(14, 1, 0, 0, 0);
        applyStimulus(15, 1, 0, 0, 0);
        checkOutput("recover_err_o", 32'(err_o), 1);
        checkOutput("recover_err_cnt", 32'(err_cnt_o), 1);
        applyStimulus(20, 1, 0, 0, 0);
        checkOutput("retrack_err_cnt", 32'(err_cnt_o), 2);

        // Stuck counter counts once; clear racing a new mismatch
        doReset();
        applyStimulus(6, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(7, 1, 0, 0, 0);
        checkOutput("stuck_err_cnt", 32'(err_cnt_o), 1);
        applyStimulus(8, 1, 0, 0, 0);
        applyStimulus(50, 1, 1, 0, 0);
        checkOutput("clr_set_err_o", 32'(err_o), 1);
        checkOutput("clr_set_err_cnt", 32'(err_cnt_o), 1);
        applyStimulus(51, 1, 1, 0, 0);
        checkOutput("clr_err_o", 32'(err_o), 0);
        checkOutput("clr_err_cnt", 32'(err_cnt_o), 0);

        // Snapshot held while stalled, dropped request, drain
        doReset();
        applyStimulus(40, 1, 0, 0, 0);
        applyStimulus(41, 1, 0, 0, 0);
        applyStimulus(42, 1, 0, 1, 0);
        checkOutput("snap_first_valid", 32'(snap_if.snap_valid_o), 1);
        checkOutput("snap_first_data", 32'(snap_if.snap_data_o), 42);
        for (int c = 43; c <= 50; c++) applyStimulus(c, 1, 0, (c == 50), 0);
        checkOutput("snap_dropped_data", 32'(snap_if.snap_data_o), 42);
        applyStimulus(51, 1, 0, 0, 1);
        checkOutput("snap_drained_valid", 32'(snap_if.snap_valid_o), 0);

        // Error counter saturation
        doReset();
        v = 10;
        applyStimulus(v, 1, 0, 0, 0);
        for (int i = 0; i < 270; i++) begin
            v = (v + 1) % MOD;
            applyStimulus(v, 1, 0, 0, 0);
            v = (v + 4) % MOD;
            applyStimulus(v, 1, 0, 0, 0);
        end
        checkOutput("sat_err_cnt", 32'(err_cnt_o), ERRMAX);

        // Asynchronous reset between edges with a snapshot pending
        doReset();
        applyStimulus(4, 1, 0, 0, 0);
        applyStimulus(9, 1, 0, 1, 0);
        #3;
        reset_i = 1'b1;
        #1;
        checkAllZero("async_reset");
        modelReset();
        #8;
        reset_i = 1'b0;
        applyStimulus(200, 1, 0, 0, 0);
        checkOutput("post_reset_err_o", 32'(err_o), 0);
        applyStimulus(201, 1, 0, 0, 0);
        checkOutput("post_reset_err_cnt", 32'(err_cnt_o), 0);

        // Randomized traffic against the model
        doReset();
        drv = $urandom_range(0, MOD - 1);
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       drv = (drv + 1) % MOD;
            else if (r == 8) drv = $urandom_range(0, MOD - 1);
            r_en  = ($urandom_range(0, 15) != 0);
            r_clr = ($urandom_range(0, 15) == 0);
            r_req = ($urandom_range(0, 2) == 0);
            r_rdy = ($urandom_range(0, 1) == 0);
            applyStimulus(drv, r_en, r_clr, r_req, r_rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
